fwd_hazard_unit: RTL
====================

// Module: fwd_hazard_unit
// PURPOSE
//  Parametrised forwarding + load-use hazard unit for the pipelined MIPS core.
//  Keeps its own tag pipeline of DEPTH in-flight destinations (EX, MEM, WB, ...),
//  fed by the instruction leaving ID. It registers forwarding selects for both
//  EX operands, raises stall on load-use, inserts bubbles, honours flush, and
//  counts stall cycles. Sits beside the ID/EX register and drives the EX operand muxes.
// PARAMETERS
//  REG_W  5   register-number width
//  DEPTH  3   tracked stages after ID (entry0=EX, entry1=MEM, entry2=WB, ...), >=2
//  CNT_W  16  stall-cycle counter width
//  SEL_W = $clog2(DEPTH+1) (localparam), forwarding-select width
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-high reset
//  id_valid     in   1      real instruction in ID this cycle
//  id_rs        in   REG_W  source A of ID instruction
//  id_rt        in   REG_W  source B of ID instruction
//  id_use_rt    in   1      ID instruction reads rt (R-type, store, branch)
//  id_rd        in   REG_W  destination of ID instruction
//  id_regwrite  in   1      ID instruction writes id_rd
//  id_memread   in   1      ID instruction is a load
//  flush        in   1      kill the ID instruction (branch/jump taken)
//  stall        out  1      hold PC and IF/ID; combinational
//  fwd_a        out  SEL_W  EX operand A select, registered
//  fwd_b        out  SEL_W  EX operand B select, registered
//  stall_cnt    out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
//  - Entry k = {valid, rd, regwrite, memread}; "live" = valid & regwrite & rd!=0.
//  - Reset (synchronous): all entries invalid; fwd_a=fwd_b=0; stall_cnt=0. stall
//    evaluates to 0 while entries are invalid.
//  - stall = id_valid & !flush & entry0.live & entry0.memread &
//    (entry0.rd==id_rs | (id_use_rt & entry0.rd==id_rt)).
//  - Each clock: entry[k] <= entry[k-1] for k=1..DEPTH-1 (always advances).
//    entry0 <= ID instruction if id_valid & !stall & !flush; otherwise a bubble
//    (valid=0).
//  - Forwarding select (computed on ID operands, registered at the same edge as
//    entry0): sel = k+1 for the smallest k in 0..DEPTH-2 with entry[k].live &
//    entry[k].rd==src; otherwise 0. Youngest match wins. Value k+1 means "take
//    the result of the stage that entry[k] moves into" (1=EX/MEM, 2=MEM/WB, ...).
//    $0 is never forwarded. fwd_b uses id_rt and is 0 if !id_use_rt.
//  - fwd_a/fwd_b <= 0 whenever a bubble is inserted (stall, flush or !id_valid).
//  - flush has priority over stall: stall=0 and a bubble is inserted.
//  - A load in entry0 never produces a forward to the consumer in ID; it always
//    produces a stall. After one bubble the load is in entry1 and sel=2 results.
//  - stall_cnt increments on each cycle with stall=1 and saturates at all-ones.
//  - Reset mid-stall: the next cycle has all entries empty, stall=0 and no
//    forwarding.
//  - Latency: entry/fwd regs update 1 cycle after ID; stall is the same cycle.
// TESTING
//  1 reset: assert reset 2 cycles mid-traffic -> entries empty, fwd_a=fwd_b=0,
//    stall=0, stall_cnt=0.
//  2 back-to-back ALU: add $3 then sub uses rs=$3 -> next cycle fwd_a=1; with one
//    independent instr in between -> fwd_a=2.
//  3 load-use: lw $5 then add rs=$5 -> stall=1 for exactly 1 cycle, stall_cnt=1,
//    then fwd_a=2; same with use via rt and id_use_rt=0 -> no stall, fwd_b=0.
//  4 priority: $4 written by both entry0 and entry1 -> fwd=1; dest $0 with
//    regwrite -> fwd=0, no stall.
//  5 flush during load-use: flush=1 with stall condition -> stall=0, bubble,
//    fwd=0, stall_cnt unchanged.
//  6 saturation: CNT_W=2, 5 stall cycles -> stall_cnt sticks at 3.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks in-flight destinations after ID,
// registers EX operand forwarding selects, stalls on load-use and counts stalls.
module fwd_hazard_unit #(
   parameter int REG_W = 5,
   parameter int DEPTH = 3,
   parameter int CNT_W = 16,
   localparam int SEL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rt,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             flush,
   output logic             stall,
   output logic [SEL_W-1:0] fwd_a,
   output logic [SEL_W-1:0] fwd_b,
   output logic [CNT_W-1:0] stall_cnt
);

   logic [DEPTH-1:0] ent_valid;
   logic [DEPTH-1:0] ent_regwrite;
   logic [DEPTH-1:0] ent_memread;
   logic [REG_W-1:0] ent_rd [DEPTH];
   logic [DEPTH-1:0] live;
   logic [SEL_W-1:0] sel_a;
   logic [SEL_W-1:0] sel_b;
   logic             issue;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   always_comb begin
      for (int k = 0; k < DEPTH; k++)
         live[k] = ent_valid[k] & ent_regwrite[k] & (ent_rd[k] != '0);
   end

   // A load in EX cannot supply its data yet, so a matching consumer must wait.
   assign stall = id_valid & ~flush & live[0] & ent_memread[0] &
                  ((ent_rd[0] == id_rs) | (id_use_rt & (ent_rd[0] == id_rt)));

   assign issue = id_valid & ~flush & ~stall;

   // Scan oldest to youngest so the youngest matching producer wins.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int k = DEPTH - 2; k >= 0; k--) begin
         if (live[k] && ent_rd[k] == id_rs) sel_a = SEL_W'(k + 1);
         if (live[k] && ent_rd[k] == id_rt) sel_b = SEL_W'(k + 1);
      end
      if (!id_use_rt) sel_b = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ent_valid <= '0;
         fwd_a     <= '0;
         fwd_b     <= '0;
         stall_cnt <= '0;
      end else begin
         for (int k = 1; k < DEPTH; k++) ent_valid[k] <= ent_valid[k-1];
         ent_valid[0] <= issue;
         fwd_a        <= issue ? sel_a : '0;
         fwd_b        <= issue ? sel_b : '0;
         if (stall) stall_cnt <= sat_inc(stall_cnt);
      end
   end

   // Payload fields need no reset; an invalid entry is never live.
   always_ff @(posedge clk) begin
      for (int k = 1; k < DEPTH; k++) begin
         ent_rd[k]       <= ent_rd[k-1];
         ent_regwrite[k] <= ent_regwrite[k-1];
         ent_memread[k]  <= ent_memread[k-1];
      end
      ent_rd[0]       <= id_rd;
      ent_regwrite[0] <= id_regwrite;
      ent_memread[0]  <= id_memread;
   end

endmodule
